// File: rtl/tl45_prefetch_queue.sv
// tl45_prefetch_queue
//
// Instruction prefetcher. It issues pipelined Wishbone reads ahead of the
// consumer and buffers the returned words in a small FIFO. Requests are
// issued only while the FIFO has room for every word already requested, so
// an ack can never find the FIFO full. Redirects (i_new_pc / i_flush) empty
// the FIFO, drop all in-flight requests and insert one idle "abort" cycle
// (cyc = stb = 0) before fetching resumes at the new address.
//
// Build option:
//   TL45_PREFETCH_ERR_ENTRY_EN  defined   : a bus error pushes an entry with
//                                           o_err = 1 and halts fetching
//                                           until the next redirect.
//                               undefined : a bus error aborts the bus cycle
//                                           and the faulting word is
//                                           re-requested; o_err is tied 0.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_flush               drop queue, refetch from the head (or oldest
//                         pending) PC
//   i_new_pc, i_pc        drop queue, fetch from i_pc (wins over i_flush)
//   o_wb_*                Wishbone pipelined master, read-only, word address
//   i_wb_ack/stall/err    Wishbone slave responses
//   i_wb_data             read data
//   o_valid, o_pc,        head entry of the queue
//   o_inst, o_err
//   o_count               entries currently held
//   i_ready               consumer takes the head when o_valid is high
module tl45_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_flush,
  input  logic                     i_new_pc,
  input  logic [31:0]              i_pc,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [29:0]              o_wb_addr,
  output logic [31:0]              o_wb_data,
  output logic [3:0]               o_wb_sel,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_err,
  input  logic [31:0]              i_wb_data,
  output logic                     o_valid,
  output logic [31:0]              o_pc,
  output logic [31:0]              o_inst,
  output logic                     o_err,
  output logic [$clog2(DEPTH):0]   o_count,
  input  logic                     i_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   ack_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          halt;
  logic          abort;

  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];
`ifdef TL45_PREFETCH_ERR_ENTRY_EN
  logic          mem_err  [DEPTH];
`endif

  logic [CW:0]   credit_sum;
  logic          stb;
  logic          accept;
  logic          resp;
  logic          resp_ok;
  logic          resp_err;
  logic          push;
  logic          pop;
  logic          redirect;
  logic          not_empty;
  logic [31:0]   redirect_pc;

  // Request side: credits cover both held entries and in-flight reads.
  assign credit_sum = {1'b0, count} + {1'b0, outstanding};
  assign stb        = (credit_sum < DEPTH_S) && !halt && !abort;
  assign accept     = stb && !i_wb_stall;

  // Responses are only meaningful while something is in flight; anything
  // arriving in the abort cycle belongs to the dropped bus cycle.
  assign resp      = (i_wb_ack || i_wb_err) && !abort && (outstanding != '0);
  assign resp_err  = resp && i_wb_err;
  assign resp_ok   = resp && !i_wb_err;
  assign not_empty = (count != '0);
  assign pop       = not_empty && i_ready;
  assign redirect  = i_new_pc || i_flush;

`ifdef TL45_PREFETCH_ERR_ENTRY_EN
  assign push = resp;
`else
  assign push = resp_ok;
`endif

  // A flush resumes at the oldest instruction not yet consumed.
  assign redirect_pc = i_new_pc  ? i_pc :
                       not_empty ? mem_pc[rd_ptr] : ack_pc;

  // ---- control state: updated once per cycle ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_pc    <= RESET_PC;
      ack_pc      <= RESET_PC;
      outstanding <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      halt        <= 1'b0;
      // Holding abort high keeps stb low until the first cycle after reset.
      abort       <= 1'b1;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      ack_pc      <= redirect_pc;
      outstanding <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      halt        <= 1'b0;
      abort       <= 1'b1;
    end else begin
      if (resp_err)
        outstanding <= '0;
      else
        outstanding <= outstanding + CW'(accept) - CW'(resp);

      if (resp_ok)
        ack_pc <= ack_pc + 32'd4;

`ifdef TL45_PREFETCH_ERR_ENTRY_EN
      abort <= 1'b0;
      if (resp_err)
        halt <= 1'b1;
      if (accept)
        fetch_pc <= fetch_pc + 32'd4;
`else
      // Retry the faulting word after a one-cycle bus abort.
      abort <= resp_err;
      if (resp_err)
        fetch_pc <= ack_pc;
      else if (accept)
        fetch_pc <= fetch_pc + 32'd4;
`endif

      count <= count + CW'(push) - CW'(pop);
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---- queue storage: written on push, never reset ----
  always_ff @(posedge i_clk) begin
    if (push && !redirect && !i_reset) begin
      mem_pc[wr_ptr]   <= ack_pc;
`ifdef TL45_PREFETCH_ERR_ENTRY_EN
      mem_inst[wr_ptr] <= resp_err ? 32'h0 : i_wb_data;
      mem_err[wr_ptr]  <= resp_err;
`else
      mem_inst[wr_ptr] <= i_wb_data;
`endif
    end
  end

  assign o_wb_stb  = stb;
  assign o_wb_cyc  = stb || (outstanding != '0);
  assign o_wb_we   = 1'b0;
  assign o_wb_addr = fetch_pc[31:2];
  assign o_wb_data = 32'h0;
  assign o_wb_sel  = 4'hF;

  // Storage is not reset, so the head is masked while the queue is empty.
  assign o_valid = not_empty;
  assign o_count = count;
  assign o_pc    = not_empty ? mem_pc[rd_ptr]   : 32'h0;
  assign o_inst  = not_empty ? mem_inst[rd_ptr] : 32'h0;
`ifdef TL45_PREFETCH_ERR_ENTRY_EN
  assign o_err   = not_empty ? mem_err[rd_ptr] : 1'b0;
`else
  assign o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tl45_prefetch_queue.sv
module tb_tl45_prefetch_queue;

  logic        i_clk;
  logic        i_reset;
  logic        i_flush;
  logic        i_new_pc;
  logic [31:0] i_pc;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [29:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic        i_wb_err;
  logic [31:0] i_wb_data;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        o_err;
  logic [2:0]  o_count;
  logic        i_ready;

  int checks  = 0;
  int errors  = 0;
  int accepts = 0;
  bit auto_ack = 0;

  tl45_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_new_pc(i_new_pc),
    .i_pc(i_pc), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data), .o_valid(o_valid), .o_pc(o_pc), .o_inst(o_inst),
    .o_err(o_err), .o_count(o_count), .i_ready(i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5C3_0F00;
  endfunction

  // Advance one clock. With auto_ack set, a one-cycle-latency slave acks
  // each accepted request in the following cycle.
  task automatic tick();
    logic        acc;
    logic [29:0] a;
    acc = (o_wb_stb === 1'b1) && (i_wb_stall === 1'b0);
    a   = o_wb_addr;
    if (acc) accepts++;
    @(posedge i_clk);
    #1;
    if (auto_ack) begin
      i_wb_ack  = acc;
      i_wb_data = acc ? inst_of({a, 2'b00}) : 32'h0;
    end
  endtask

  task automatic do_reset();
    i_reset = 1; i_flush = 0; i_new_pc = 0; i_pc = 0;
    i_wb_ack = 0; i_wb_stall = 0; i_wb_err = 0; i_wb_data = 0;
    i_ready = 0; auto_ack = 0;
    tick(); tick();
    i_reset = 0;
    tick();
    accepts = 0;
  endtask

  task automatic test_reset();
    i_reset = 1; i_flush = 0; i_new_pc = 0; i_pc = 0;
    i_wb_ack = 0; i_wb_stall = 0; i_wb_err = 0; i_wb_data = 0; i_ready = 0;
    tick(); tick();
    checks++; if ({o_wb_cyc, o_wb_stb, o_wb_we, o_valid, o_err} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {o_wb_cyc, o_wb_stb, o_wb_we, o_valid, o_err}); end
    checks++; if (o_wb_sel !== 4'hF) begin errors++;
      $display("FAIL reset_sel: got %h required f", o_wb_sel); end
    checks++; if ({o_wb_addr, o_wb_data, o_pc, o_inst, o_count} !== 129'b0) begin errors++;
      $display("FAIL reset_data: addr %h data %h pc %h inst %h count %0d required all 0",
               o_wb_addr, o_wb_data, o_pc, o_inst, o_count); end
    i_reset = 0;
    tick();
    checks++; if (o_wb_stb !== 1'b1 || o_wb_cyc !== 1'b1 || o_wb_addr !== 30'h0) begin errors++;
      $display("FAIL reset_first_stb: stb %b cyc %b addr %h required 1 1 0", o_wb_stb, o_wb_cyc, o_wb_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    auto_ack = 1; i_ready = 1;
    tick(); tick();
    for (int k = 2; k < 10; k++) begin
      checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'(4*(k-2)) || o_inst !== inst_of(32'(4*(k-2))) ||
          o_wb_addr !== 30'(k) || o_count !== 3'd1) begin
        errors++;
        $display("FAIL stream_%0d: valid %b pc %h inst %h addr %h count %0d required 1 %h %h %h 1",
                 k, o_valid, o_pc, o_inst, o_wb_addr, o_count,
                 32'(4*(k-2)), inst_of(32'(4*(k-2))), 30'(k));
      end
      tick();
    end
  endtask

  task automatic test_credit();
    do_reset();
    auto_ack = 1; i_ready = 0;
    repeat (10) tick();
    checks++; if (accepts !== 4 || o_count !== 3'd4 || o_wb_stb !== 1'b0 || o_wb_cyc !== 1'b0) begin errors++;
      $display("FAIL credit_full: accepts %0d count %0d stb %b cyc %b required 4 4 0 0",
               accepts, o_count, o_wb_stb, o_wb_cyc); end
    checks++; if (o_pc !== 32'h0 || o_inst !== inst_of(32'h0)) begin errors++;
      $display("FAIL credit_head_hold: pc %h inst %h required 0 %h", o_pc, o_inst, inst_of(32'h0)); end
    i_ready = 1;
    tick();
    i_ready = 0;
    repeat (5) tick();
    checks++; if (accepts !== 5 || o_count !== 3'd4 || o_pc !== 32'h4) begin errors++;
      $display("FAIL credit_one_pop: accepts %0d count %0d pc %h required 5 4 4", accepts, o_count, o_pc); end
  endtask

  task automatic test_push_pop_edge();
    do_reset();
    auto_ack = 0; i_ready = 0;
    repeat (4) tick();
    checks++; if (o_wb_stb !== 1'b0 || o_wb_cyc !== 1'b1) begin errors++;
      $display("FAIL edge_outstanding: stb %b cyc %b required 0 1", o_wb_stb, o_wb_cyc); end
    i_wb_ack = 1;
    i_wb_data = inst_of(32'h0); tick();
    i_wb_data = inst_of(32'h4); tick();
    i_wb_data = inst_of(32'h8); tick();
    checks++; if (o_count !== 3'd3) begin errors++;
      $display("FAIL edge_count3: got %0d required 3", o_count); end
    i_wb_data = inst_of(32'hC); i_ready = 1; tick();
    i_wb_ack = 0; i_ready = 0;
    checks++; if (o_count !== 3'd3 || o_pc !== 32'h4 || o_inst !== inst_of(32'h4)) begin errors++;
      $display("FAIL edge_push_pop: count %0d pc %h inst %h required 3 4 %h",
               o_count, o_pc, o_inst, inst_of(32'h4)); end
    checks++; if (o_wb_stb !== 1'b1 || o_wb_addr !== 30'h4) begin errors++;
      $display("FAIL edge_resume: stb %b addr %h required 1 4", o_wb_stb, o_wb_addr); end
  endtask

  task automatic test_new_pc();
    do_reset();
    auto_ack = 0; i_ready = 1;
    tick(); tick();
    i_wb_stall = 1; i_wb_ack = 1; i_wb_data = 32'hDEADBEEF; i_new_pc = 1; i_pc = 32'h100;
    checks++; if (o_wb_cyc !== 1'b1) begin errors++;
      $display("FAIL newpc_cyc_before: got %b required 1", o_wb_cyc); end
    tick();
    i_new_pc = 0; i_wb_stall = 0;
    checks++; if ({o_wb_cyc, o_wb_stb, o_valid} !== 3'b0 || o_count !== 3'd0) begin errors++;
      $display("FAIL newpc_abort: cyc %b stb %b valid %b count %0d required 0 0 0 0",
               o_wb_cyc, o_wb_stb, o_valid, o_count); end
    tick();
    i_wb_ack = 0;
    checks++; if (o_valid !== 1'b0 || o_wb_stb !== 1'b1 || o_wb_addr !== 30'h40) begin errors++;
      $display("FAIL newpc_resume: valid %b stb %b addr %h required 0 1 40", o_valid, o_wb_stb, o_wb_addr); end
    tick();
    i_wb_ack = 1; i_wb_data = 32'h12345678; i_wb_stall = 1;
    tick();
    i_wb_ack = 0; i_wb_stall = 0;
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_inst !== 32'h12345678) begin errors++;
      $display("FAIL newpc_entry: valid %b pc %h inst %h required 1 100 12345678", o_valid, o_pc, o_inst); end
  endtask

  task automatic test_flush();
    do_reset();
    auto_ack = 1; i_ready = 0;
    repeat (10) tick();
    i_ready = 1;
    tick(); tick();
    i_ready = 0;
    checks++; if (o_count !== 3'd2 || o_pc !== 32'h8) begin errors++;
      $display("FAIL flush_setup: count %0d pc %h required 2 8", o_count, o_pc); end
    i_flush = 1;
    tick();
    i_flush = 0;
    checks++; if ({o_wb_cyc, o_wb_stb, o_valid} !== 3'b0 || o_count !== 3'd0) begin errors++;
      $display("FAIL flush_abort: cyc %b stb %b valid %b count %0d required 0 0 0 0",
               o_wb_cyc, o_wb_stb, o_valid, o_count); end
    tick();
    checks++; if (o_wb_stb !== 1'b1 || o_wb_addr !== 30'h2 || o_valid !== 1'b0) begin errors++;
      $display("FAIL flush_refetch: stb %b addr %h valid %b required 1 2 0", o_wb_stb, o_wb_addr, o_valid); end
    i_ready = 1;
    tick(); tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h8 || o_inst !== inst_of(32'h8)) begin errors++;
      $display("FAIL flush_entry: valid %b pc %h inst %h required 1 8 %h", o_valid, o_pc, o_inst, inst_of(32'h8)); end
  endtask

  task automatic test_err();
    do_reset();
    auto_ack = 0; i_ready = 0;
    i_new_pc = 1; i_pc = 32'h20;
    tick();
    i_new_pc = 0;
    tick();
    checks++; if (o_wb_stb !== 1'b1 || o_wb_addr !== 30'h8) begin errors++;
      $display("FAIL err_issue: stb %b addr %h required 1 8", o_wb_stb, o_wb_addr); end
    tick();
    i_wb_stall = 1; i_wb_ack = 1; i_wb_err = 1;
    tick();
    i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0;
`ifdef TL45_PREFETCH_ERR_ENTRY_EN
    checks++; if (o_valid !== 1'b1 || o_err !== 1'b1 || o_pc !== 32'h20 || o_inst !== 32'h0) begin errors++;
      $display("FAIL err_entry: valid %b err %b pc %h inst %h required 1 1 20 0", o_valid, o_err, o_pc, o_inst); end
    repeat (3) tick();
    checks++; if (o_wb_stb !== 1'b0 || o_wb_cyc !== 1'b0) begin errors++;
      $display("FAIL err_halt: stb %b cyc %b required 0 0", o_wb_stb, o_wb_cyc); end
    i_flush = 1;
    tick();
    i_flush = 0;
    tick();
    checks++; if (o_wb_stb !== 1'b1 || o_wb_addr !== 30'h8 || o_valid !== 1'b0) begin errors++;
      $display("FAIL err_flush_resume: stb %b addr %h valid %b required 1 8 0", o_wb_stb, o_wb_addr, o_valid); end
`else
    checks++; if ({o_wb_cyc, o_wb_stb, o_valid, o_err} !== 4'b0) begin errors++;
      $display("FAIL err_abort: cyc %b stb %b valid %b err %b required 0 0 0 0", o_wb_cyc, o_wb_stb, o_valid, o_err); end
    tick();
    checks++; if (o_wb_stb !== 1'b1 || o_wb_addr !== 30'h8 || o_valid !== 1'b0) begin errors++;
      $display("FAIL err_retry: stb %b addr %h valid %b required 1 8 0", o_wb_stb, o_wb_addr, o_valid); end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    auto_ack = 1; i_ready = 1;
    i_new_pc = 1; i_pc = 32'hFFFF_FFFC;
    tick();
    i_new_pc = 0;
    tick();
    checks++; if (o_wb_stb !== 1'b1 || o_wb_addr !== 30'h3FFF_FFFF) begin errors++;
      $display("FAIL wrap_top: stb %b addr %h required 1 3fffffff", o_wb_stb, o_wb_addr); end
    tick();
    checks++; if (o_wb_addr !== 30'h0) begin errors++;
      $display("FAIL wrap_addr: got %h required 0", o_wb_addr); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'hFFFF_FFFC || o_inst !== inst_of(32'hFFFF_FFFC)) begin errors++;
      $display("FAIL wrap_entry_top: valid %b pc %h inst %h required 1 fffffffc %h",
               o_valid, o_pc, o_inst, inst_of(32'hFFFF_FFFC)); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_inst !== inst_of(32'h0)) begin errors++;
      $display("FAIL wrap_entry_zero: valid %b pc %h inst %h required 1 0 %h", o_valid, o_pc, o_inst, inst_of(32'h0)); end
  endtask

  task automatic test_reset_mid();
    checks++; if (o_wb_cyc !== 1'b1) begin errors++;
      $display("FAIL rstmid_busy: cyc %b required 1", o_wb_cyc); end
    auto_ack = 0;
    i_reset = 1; i_flush = 1; i_new_pc = 1; i_pc = 32'h400; i_wb_ack = 1;
    tick();
    checks++; if ({o_wb_cyc, o_wb_stb, o_valid} !== 3'b0 || o_count !== 3'd0 || o_wb_addr !== 30'h0) begin errors++;
      $display("FAIL rstmid_state: cyc %b stb %b valid %b count %0d addr %h required 0 0 0 0 0",
               o_wb_cyc, o_wb_stb, o_valid, o_count, o_wb_addr); end
    i_reset = 0; i_flush = 0; i_new_pc = 0; i_wb_ack = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_credit();
    test_push_pop_edge();
    test_new_pc();
    test_flush();
    test_err();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl45_prefetch_queue.md
TL45_PREFETCH_QUEUE -- requirements
Module: tl45_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries and max outstanding bus requests; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0: fetch address loaded on reset.
REQ-003 SHALL have clock i_clk (input, 1) and reset i_reset (input, 1); reset is synchronous and active-high.
REQ-004 SHALL have control inputs: i_flush (1), i_new_pc (1), i_pc (32, redirect target).
REQ-005 SHALL have Wishbone master outputs: o_wb_cyc (1), o_wb_stb (1), o_wb_we (1, always 0), o_wb_addr (30, word address), o_wb_data (32, always 0), o_wb_sel (4, always 4'hF).
REQ-006 SHALL have Wishbone master inputs: i_wb_ack (1), i_wb_stall (1), i_wb_err (1), i_wb_data (32).
REQ-007 SHALL have consumer outputs: o_valid (1), o_pc (32), o_inst (32), o_err (1), o_count ($clog2(DEPTH)+1, entries held); consumer input i_ready (1).

Function
REQ-008 SHALL hold fetch_pc, the next address to request; o_wb_addr = fetch_pc[31:2].
REQ-009 SHALL assert o_wb_stb only when count + outstanding < DEPTH, not halted, and not in the abort cycle.
REQ-010 SHALL treat stb && !i_wb_stall as accepted: fetch_pc += 4, outstanding += 1; stb may stay high for back-to-back requests.
REQ-011 SHALL hold o_wb_cyc high whenever o_wb_stb is high or outstanding > 0; low otherwise.
REQ-012 SHALL track ack_pc, the PC of the oldest outstanding request; each ack without err pushes {ack_pc, i_wb_data, err=0}, ack_pc += 4, outstanding -= 1.
REQ-013 SHALL make a pushed entry visible on o_valid/o_pc/o_inst the cycle after its ack; entries are delivered strictly in request order.
REQ-014 SHALL pop the head when o_valid && i_ready; i_ready ignored when o_valid is low; head outputs stable while o_valid && !i_ready.
REQ-015 SHALL support push and pop in the same cycle with count unchanged, including at count == DEPTH-1 and count == 1.
REQ-016 SHALL never overflow: the credit rule of REQ-009 guarantees space for every outstanding ack; acks with outstanding == 0 are ignored.
REQ-017 SHALL drive o_count and o_valid from registers; o_valid = (count != 0).
REQ-018 On i_new_pc: empty queue, outstanding := 0, fetch_pc := ack_pc := i_pc; next cycle cyc = stb = 0 (abort cycle); fetching resumes the cycle after.
REQ-019 On i_flush without i_new_pc: empty queue, outstanding := 0, fetch_pc := ack_pc := head PC if queue non-empty, else ack_pc; same abort-cycle timing as REQ-018.
REQ-020 SHALL give i_new_pc priority over i_flush, and both priority over any same-cycle ack, push, or pop, which are discarded.
REQ-021 SHALL, during the abort cycle, ignore i_wb_ack and i_wb_err from the aborted cycle.
REQ-022 SHALL wrap fetch_pc and ack_pc modulo 2^32 (32'hFFFFFFFC + 4 = 0).

Reset
REQ-023 On i_reset: queue empty, outstanding = 0, fetch_pc = ack_pc = RESET_PC, halt cleared, all outputs 0 except o_wb_sel = 4'hF; first stb the cycle after reset deasserts.
REQ-024 i_reset SHALL override i_flush, i_new_pc, and bus inputs mid-transaction; the bus cycle drops immediately (cyc registered low).

Configuration
REQ-025 With TL45_PREFETCH_ERR_ENTRY_EN defined: i_wb_err (with ack) pushes {ack_pc, 32'h0, err=1}, drops outstanding to 0, and sets halt (no stb) until i_flush/i_new_pc; o_err carries the entry flag.
REQ-026 Without TL45_PREFETCH_ERR_ENTRY_EN: i_wb_err pushes nothing, aborts the cycle (outstanding := 0, one abort cycle), sets fetch_pc := ack_pc to retry the faulting word; queue kept; o_err tied 0.

Verification
REQ-027 Reset, RESET_PC=0, ack 1 cycle after each accept, i_ready=1 -> addrs 0,1,2..., o_pc 0,4,8, o_inst matches data, one entry per cycle in steady state.
REQ-028 DEPTH=4, i_ready=0, acks always -> exactly 4 accepts, o_count=4, stb low; one pop -> exactly one new accept.
REQ-029 Two outstanding, i_new_pc=1, i_pc=32'h100 same cycle as an ack -> ack discarded, o_valid=0, one cycle cyc=0, then addr 30'h40.
REQ-030 Queue holds PCs 8,12; i_flush=1 -> queue empty; refetch starts at addr 2 (PC 8).
REQ-031 err on PC 32'h20: with macro -> o_valid, o_err=1, o_pc=32'h20, no further stb until flush; without -> no entry, abort cycle, PC 32'h20 reissued.
REQ-032 fetch_pc=32'hFFFFFFFC accepted -> next addr 0; o_pc of the following entry = 0.
